carry_save_resolver: RTL and testbench

Multi-cycle carry-propagate adder for the multiply functional unit. It accepts the redundant sum/carry vector pair produced by the final carry-save stage of the Wallace tree and resolves it into a single binary product, CHUNK bits per cycle. A valid/ready handshake sits on each side, and a tag rides along with the operation so the result can be broadcast on the common data bus. A synchronous flush kills an in-flight operation on squash.

---
 rtl/mul_pkg.sv | 19 +
 rtl/carry_save_resolver_if.sv | 27 ++
 rtl/cpa_chunk.sv | 14 +
 rtl/carry_save_resolver.sv | 131 +++++++++++++
 tb/tb_carry_save_resolver.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared parameters and state encoding for the multiply unit's carry-propagate resolver.
package mul_pkg;

  localparam int unsigned WIDTH    = 55;
  localparam int unsigned CHUNK    = 8;
  localparam int unsigned TAG_W    = 4;
  localparam int unsigned NCHUNK   = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned KW       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned IW       = $clog2(WIDTH);
  // Real bits in the top chunk; the remainder of that chunk adder is zero padding.
  localparam int unsigned TOP_BITS = WIDTH - (NCHUNK - 1) * CHUNK;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/carry_save_resolver_if.sv
// Issue/result handshake bundle between the Wallace tree, the resolver and the data bus.
interface carry_save_resolver_if;
  import mul_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_vec;
  logic [WIDTH-1:0] carry_vec;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, sum_vec, carry_vec, in_tag, out_ready,
    input  in_ready, out_valid, result, carry_out, out_tag
  );

  modport slave (
    input  flush, in_valid, sum_vec, carry_vec, in_tag, out_ready,
    output in_ready, out_valid, result, carry_out, out_tag
  );

endinterface

// File: rtl/cpa_chunk.sv
// Combinational chunk adder shared across all chunk positions of the resolver.
module cpa_chunk #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             cin,
  output logic [Width-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{Width{1'b0}}, cin};

endmodule

// File: rtl/carry_save_resolver.sv
// Resolves a carry-save sum/carry pair into a binary product one chunk per cycle.
module carry_save_resolver
  import mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  carry_save_resolver_if.slave bus
);

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cin_q, cin_d;
  logic             cout_q, cout_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [CHUNK-1:0] a, b, s;
  logic             cout;
  logic             final_carry;
  int unsigned      chunk_base;

  assign chunk_base = 32'(k_q) * CHUNK;

  // Bits past WIDTH in the top chunk read as zero.
  always_comb begin
    a = '0;
    b = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (chunk_base + i < WIDTH) begin
        a[i] = sum_q[IW'(chunk_base + i)];
        b[i] = carry_q[IW'(chunk_base + i)];
      end
    end
  end

  cpa_chunk #(
    .Width(CHUNK)
  ) u_cpa (
    .a   (a),
    .b   (b),
    .cin (cin_q),
    .s   (s),
    .cout(cout)
  );

  // With a padded top chunk, the carry out of bit WIDTH-1 lands in the first pad bit.
  if (TOP_BITS < CHUNK) begin : g_pad
    assign final_carry = s[TOP_BITS];
  end else begin : g_nopad
    assign final_carry = cout;
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    result_d = result_q;
    cin_d    = cin_q;
    cout_d   = cout_q;
    tag_d    = tag_q;

    if (bus.flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            state_d = StAdd;
            sum_d   = bus.sum_vec;
            carry_d = bus.carry_vec;
            tag_d   = bus.in_tag;
            cin_d   = 1'b0;
            k_d     = '0;
          end
        end
        StAdd: begin
          for (int unsigned i = 0; i < CHUNK; i++) begin
            if (chunk_base + i < WIDTH) begin
              result_d[IW'(chunk_base + i)] = s[i];
            end
          end
          cin_d = cout;
          k_d   = k_q + 1'b1;
          if (k_q == KW'(NCHUNK - 1)) begin
            state_d = StDone;
            cout_d  = final_carry;
            k_d     = '0;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      k_q      <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      result_q <= '0;
      cin_q    <= 1'b0;
      cout_q   <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cin_q    <= cin_d;
      cout_q   <= cout_d;
      tag_q    <= tag_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
  assign bus.out_tag   = tag_q;

endmodule

// File: tb/tb_carry_save_resolver.sv
// Self-checking bench: directed vectors plus a transaction-level model checked every cycle.
module tb_carry_save_resolver;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  carry_save_resolver_if bus ();

  carry_save_resolver dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one operation in flight, result visible NCHUNK edges after accept.
  logic             have_op = 1'b0;
  int unsigned      age = 0;
  logic [WIDTH-1:0] exp_res = '0;
  logic             exp_co = 1'b0;
  logic [TAG_W-1:0] exp_tag = '0;

  always @(posedge clk) begin
    if (reset || bus.flush) begin
      have_op <= 1'b0;
    end else if (!have_op) begin
      if (bus.in_valid) begin
        have_op           <= 1'b1;
        age               <= 0;
        {exp_co, exp_res} <= {1'b0, bus.sum_vec} + {1'b0, bus.carry_vec};
        exp_tag           <= bus.in_tag;
      end
    end else if (age >= NCHUNK) begin
      if (bus.out_ready) have_op <= 1'b0;
    end else begin
      age <= age + 1;
    end
  end

  always @(negedge clk) begin
    logic exp_v;
    exp_v = have_op && (age >= NCHUNK);
    check("mc_out_valid", 64'(bus.out_valid), 64'(exp_v));
    check("mc_in_ready", 64'(bus.in_ready), 64'(!have_op));
    if (exp_v) begin
      check("mc_result", 64'(bus.result), 64'(exp_res));
      check("mc_carry_out", 64'(bus.carry_out), 64'(exp_co));
      check("mc_out_tag", 64'(bus.out_tag), 64'(exp_tag));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                       input logic [TAG_W-1:0] t);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    check("issue_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.sum_vec   = s;
    bus.carry_vec = c;
    bus.in_tag    = t;
    step();
    bus.in_valid  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int               lat;
    logic [63:0]      r0, r1;
    logic [WIDTH-1:0] held_res;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.sum_vec   = '0;
    bus.carry_vec = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    #1;
    step();
    step();
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_carry_out", 64'(bus.carry_out), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    reset = 1'b0;
    step();

    // 1 + 2, consumer always ready.
    issue(55'd1, 55'd2, 4'd3);
    wait_valid(lat);
    check("t1_latency", 64'(lat), 64'd7);
    check("t1_result", 64'(bus.result), 64'd3);
    check("t1_carry_out", 64'(bus.carry_out), 64'd0);
    check("t1_out_tag", 64'(bus.out_tag), 64'd3);
    check("t1_in_ready_busy", 64'(bus.in_ready), 64'd0);
    step();
    check("t1_in_ready_after", 64'(bus.in_ready), 64'd1);
    check("t1_out_valid_after", 64'(bus.out_valid), 64'd0);

    // Carry ripples through every chunk boundary and out the top.
    issue({WIDTH{1'b1}}, 55'd2, 4'd7);
    wait_valid(lat);
    check("t2_latency", 64'(lat), 64'd7);
    check("t2_result", 64'(bus.result), 64'd1);
    check("t2_carry_out", 64'(bus.carry_out), 64'd1);
    check("t2_out_tag", 64'(bus.out_tag), 64'd7);
    step();

    // Backpressure: result held, new requests ignored.
    bus.out_ready = 1'b0;
    issue(55'h123456789ABCD, 55'h0FEDCBA987654, 4'd9);
    wait_valid(lat);
    check("t3_result", 64'(bus.result), 64'h2222222222221);
    held_res = bus.result;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid  = 1'b1;
      bus.sum_vec   = 55'(i + 100);
      bus.carry_vec = 55'd4;
      bus.in_tag    = 4'd1;
      step();
      check("t3_hold_valid", 64'(bus.out_valid), 64'd1);
      check("t3_hold_ready", 64'(bus.in_ready), 64'd0);
      check("t3_hold_result", 64'(bus.result), 64'(held_res));
      check("t3_hold_tag", 64'(bus.out_tag), 64'd9);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("t3_release_valid", 64'(bus.out_valid), 64'd0);
    check("t3_release_ready", 64'(bus.in_ready), 64'd1);

    // Flush on the third chunk edge kills the operation.
    issue(55'h7777, 55'h8888, 4'd2);
    step();
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("t4_flush_ready", 64'(bus.in_ready), 64'd1);
    check("t4_flush_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 8; i++) step();
    check("t4_no_late_valid", 64'(bus.out_valid), 64'd0);
    issue(55'd5, 55'd6, 4'd4);
    wait_valid(lat);
    check("t4_result", 64'(bus.result), 64'd11);
    check("t4_out_tag", 64'(bus.out_tag), 64'd4);
    step();

    // Reset while DONE and consumer ready: operation discarded.
    bus.out_ready = 1'b0;
    issue(55'd7, 55'd8, 4'd2);
    wait_valid(lat);
    check("t5_result", 64'(bus.result), 64'd15);
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    step();
    reset = 1'b0;
    check("t5_rst_valid", 64'(bus.out_valid), 64'd0);
    check("t5_rst_result", 64'(bus.result), 64'd0);
    check("t5_rst_tag", 64'(bus.out_tag), 64'd0);
    check("t5_rst_ready", 64'(bus.in_ready), 64'd1);

    // Flush while DONE and consumer ready.
    bus.out_ready = 1'b0;
    issue(55'd9, 55'd10, 4'd5);
    wait_valid(lat);
    check("t6_result", 64'(bus.result), 64'd19);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.flush = 1'b0;
    check("t6_flush_valid", 64'(bus.out_valid), 64'd0);
    check("t6_flush_ready", 64'(bus.in_ready), 64'd1);

    // Random traffic with stalls and rare flushes; the model checks every cycle.
    for (int cyc = 0; cyc < 15000; cyc++) begin
      r0 = {$urandom(), $urandom()};
      r1 = {$urandom(), $urandom()};
      bus.in_valid  = ($urandom_range(0, 1) == 1);
      bus.sum_vec   = r0[WIDTH-1:0];
      bus.carry_vec = r1[WIDTH-1:0] & ~55'd1;
      bus.in_tag    = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 99) == 0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
